// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO family.
package fifo_pkg;

    // Pointer/address width for a given entry count (ceil(log2)).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (fall-through) read.
module fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with level flags, tlast carriage and optional store-and-forward
// release; an oversize packet that fills the FIFO is let through to avoid deadlock.
module axis_fifo_pkt
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 32,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    parameter int PACKET_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    write_tdata,
    input  logic                     write_tlast,
    input  logic                     write_tvalid,
    output logic                     write_tready,
    output logic [DATA_WIDTH-1:0]    read_tdata,
    output logic                     read_tlast,
    output logic                     read_tvalid,
    input  logic                     read_tready,
    output logic [clog2(DEPTH):0]    count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     oversize
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW + 1)'(AFULL_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW + 1)'(AEMPTY_LEVEL);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] pkt_cnt_q, pkt_cnt_d;
    logic        wready_q, wready_d;
    logic        release_q, release_d;
    logic        oversize_q, oversize_d;
    logic        wr_en, rd_en, wr_last, rd_last;
    entry_t      wr_entry, rd_entry;

    assign wr_entry = '{last: write_tlast, data: write_tdata};

    fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign oversize     = oversize_q;
    assign write_tready = wready_q;
    assign read_tdata   = rd_entry.data;
    assign read_tlast   = rd_entry.last;

    // In packet mode the head is only exposed once a whole packet is stored.
    assign read_tvalid = !empty && (PACKET_MODE == 0 || pkt_cnt_q != '0 || release_q);

    assign wr_en   = write_tvalid && wready_q;
    assign rd_en   = read_tvalid && read_tready;
    assign wr_last = wr_en && write_tlast;
    assign rd_last = rd_en && rd_entry.last;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW + 1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (AW + 1)'(rd_en);
        pkt_cnt_d  = pkt_cnt_q;
        release_d  = release_q;
        oversize_d = oversize_q;
        if (wr_last && !rd_last)      pkt_cnt_d = pkt_cnt_q + 1'b1;
        else if (!wr_last && rd_last) pkt_cnt_d = pkt_cnt_q - 1'b1;
        // A full FIFO holding no tlast can never complete its packet: drain it anyway.
        if (PACKET_MODE != 0 && full && pkt_cnt_q == '0) begin
            release_d  = 1'b1;
            oversize_d = 1'b1;
        end else if (rd_last) begin
            release_d  = 1'b0;
        end
        wready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            wready_q   <= 1'b0;
            release_q  <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            wready_q   <= wready_d;
            release_q  <= release_d;
            oversize_q <= oversize_d;
        end
    end

endmodule
